// File: rtl/register_en4_pkg.sv
// Shared constants for the enable register slice.
package register_en4_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  // Selects bit idx of a reset pattern; keeps the generate loop free of slicing noise.
  function automatic logic reset_bit(input logic [63:0] pattern, input int unsigned idx);
    return pattern[idx];
  endfunction

endpackage

// File: rtl/register_en4_dff_en.sv
// Single flop with load enable and a synchronous active-low reset to a per-bit value.
module dff_en #(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic d,
  output logic q
);

  // Reset wins over enable; with neither, the flop holds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= RESET_BIT;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/register_en4.sv
// WIDTH-bit storage register: one dff_en per bit, all sharing a common enable and reset.
module register_en4
  import register_en4_pkg::*;
#(
  parameter int unsigned       WIDTH       = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_q
);

  localparam logic [63:0] RESET_PATTERN = 64'(RESET_VALUE);

  // Every bit loads on the same enable; there are no partial writes.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    dff_en #(
      .RESET_BIT (reset_bit(RESET_PATTERN, i))
    ) u_dff (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .en    (i_en),
      .d     (i_d[i]),
      .q     (o_q[i])
    );
  end

endmodule

// File: tb/tb_register_en4.sv
// Directed bench for register_en4: default, non-zero reset value, and 8-bit instances.
module tb_register_en4;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] d4;
  logic [7:0] d8;
  logic [3:0] q_a;
  logic [3:0] q_b;
  logic [7:0] q_c;

  int checks;
  int errors;

  // Clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  register_en4 u_dut_a (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_d     (d4),
    .i_en    (en),
    .o_q     (q_a)
  );

  register_en4 #(.WIDTH(4), .RESET_VALUE(4'b1001)) u_dut_b (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_d     (d4),
    .i_en    (en),
    .o_q     (q_b)
  );

  register_en4 #(.WIDTH(8), .RESET_VALUE(8'h00)) u_dut_c (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_d     (d8),
    .i_en    (en),
    .o_q     (q_c)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver tasks: inputs change on the falling edge, outputs are sampled 1 after rising.
  task automatic drive(input logic r, input logic e, input logic [3:0] v4, input logic [7:0] v8);
    @(negedge clk);
    rst_n = r;
    en    = e;
    d4    = v4;
    d8    = v8;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    en     = 1'b0;
    d4     = 4'h0;
    d8     = 8'h00;

    // Reset held for two edges
    step();
    step();
    check("reset_a", 8'(q_a), 8'h00);
    check("reset_b", 8'(q_b), 8'h09);
    check("reset_c", q_c, 8'h00);

    // Release reset with load on the same edge
    drive(1'b1, 1'b1, 4'hF, 8'hA5);
    step();
    check("load_a", 8'(q_a), 8'h0F);
    check("load_b", 8'(q_b), 8'h0F);
    check("load_c_a5", q_c, 8'hA5);

    // Hold: enable low, data changes
    drive(1'b1, 1'b0, 4'hF, 8'hA5);
    #2 d4 = 4'h0;
    d8 = 8'h3C;
    step();
    check("hold1_a", 8'(q_a), 8'h0F);
    step();
    check("hold2_a", 8'(q_a), 8'h0F);
    check("hold_c", q_c, 8'hA5);

    // Reload
    drive(1'b1, 1'b1, 4'h0, 8'h3C);
    step();
    check("reload_a", 8'(q_a), 8'h00);
    check("reload_c", q_c, 8'h3C);

    // Reset priority over a pending load
    drive(1'b1, 1'b1, 4'hA, 8'h5A);
    step();
    check("pre_prio_a", 8'(q_a), 8'h0A);
    drive(1'b0, 1'b1, 4'h5, 8'hFF);
    step();
    check("prio_a", 8'(q_a), 8'h00);
    check("prio_b", 8'(q_b), 8'h09);
    check("prio_c", q_c, 8'h00);

    // Reset pulse entirely between edges has no effect
    drive(1'b1, 1'b1, 4'h6, 8'h66);
    step();
    check("pre_pulse_a", 8'(q_a), 8'h06);
    drive(1'b1, 1'b0, 4'h6, 8'h66);
    #1 rst_n = 1'b0;
    #1;
    check("mid_pulse_a", 8'(q_a), 8'h06);
    #1 rst_n = 1'b1;
    step();
    check("pulse_a", 8'(q_a), 8'h06);
    check("pulse_b", 8'(q_b), 8'h06);
    check("pulse_c", q_c, 8'h66);

    // Reset during hold, held across an edge
    drive(1'b0, 1'b0, 4'h6, 8'h66);
    step();
    check("hold_rst_a", 8'(q_a), 8'h00);
    check("hold_rst_b", 8'(q_b), 8'h09);

    // Back-to-back loads
    drive(1'b1, 1'b1, 4'h3, 8'h12);
    step();
    check("b2b_3", 8'(q_a), 8'h03);
    check("b2b_c_12", q_c, 8'h12);
    drive(1'b1, 1'b1, 4'hC, 8'h34);
    step();
    check("b2b_c", 8'(q_a), 8'h0C);
    check("b2b_c_34", q_c, 8'h34);
    drive(1'b1, 1'b1, 4'h7, 8'hA5);
    step();
    check("b2b_7", 8'(q_a), 8'h07);
    check("b2b_7_b", 8'(q_b), 8'h07);
    check("b2b_c_a5", q_c, 8'hA5);

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
